auth_controller: RTL and testbench

//  Password-controlled access stage, directly upstream of the game controller.

---
 rtl/auth_pkg.sv | 18 +
 rtl/auth_controller_if.sv | 24 ++
 rtl/lockout_timer.sv | 39 +++
 rtl/auth_controller.sv | 143 ++++++++++++++
 tb/tb_auth_controller.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/auth_pkg.sv
// Shared definitions for the access-control stage and the game controller:
// state codes, display codes and entry length.
package auth_pkg;

  typedef enum logic [2:0] {
    ST_ID_ENTRY  = 3'd0,
    ST_PWD_ENTRY = 3'd1,
    ST_AUTH_OK   = 3'd2,
    ST_LOCKOUT   = 3'd3
  } auth_state_t;

  localparam logic [3:0] DISP_IDLE = 4'hF;
  localparam logic [3:0] DISP_ERR  = 4'hE;
  localparam logic [3:0] DISP_MASK = 4'hA;

  localparam int NUM_DIGITS = 4;

endpackage

// File: rtl/auth_controller_if.sv
// Keypad-side and game-controller-side signals of the access-control stage.
// The slave modport is the controller itself.
interface auth_controller_if;

  logic [3:0] PassDigit;
  logic       LoadPassNumber;
  logic       LogOut;
  logic       SuccessAuth;
  logic       RLed;
  logic       GLed;
  logic       Locked;
  logic [3:0] PwdDisp;

  modport master (
    output PassDigit, LoadPassNumber, LogOut,
    input  SuccessAuth, RLed, GLed, Locked, PwdDisp
  );

  modport slave (
    input  PassDigit, LoadPassNumber, LogOut,
    output SuccessAuth, RLed, GLed, Locked, PwdDisp
  );

endinterface

// File: rtl/lockout_timer.sv
// Lockout interval timer: counts 0..LOCK_CYCLES-1 after start, busy meanwhile,
// done pulses for one cycle on the terminal count.
module lockout_timer #(
  parameter int LOCK_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam int CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(LOCK_CYCLES - 1);

  logic [CW-1:0] cnt_reg;
  logic          busy_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (start) begin
      cnt_reg  <= '0;
      busy_reg <= 1'b1;
    end else if (busy_reg) begin
      if (cnt_reg == LAST) begin
        cnt_reg  <= '0;
        busy_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign busy = busy_reg;
  assign done = busy_reg && (cnt_reg == LAST);

endmodule

// File: rtl/auth_controller.sv
// Password-controlled access stage: 4-digit ID then 4-digit password, one digit
// per press, with a timed lockout after MAX_FAIL consecutive failed entries.
module auth_controller
  import auth_pkg::*;
#(
  parameter logic [15:0] USER_ID     = 16'h1234,
  parameter logic [15:0] PASSWORD    = 16'h5678,
  parameter int          MAX_FAIL    = 3,
  parameter int          LOCK_CYCLES = 50_000_000
) (
  input logic              clk,
  input logic              rst,
  auth_controller_if.slave bus
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_DIGITS - 1);

  logic [3:0]  id_nib  [NUM_DIGITS];
  logic [3:0]  pwd_nib [NUM_DIGITS];

  auth_state_t state_reg;
  logic [1:0]  idx_reg;
  logic        sofar_reg;
  logic [2:0]  fail_cnt_reg;
  logic        success_reg;
  logic        rled_reg;
  logic        gled_reg;
  logic        locked_reg;
  logic [3:0]  disp_reg;

  logic        digit_ok;
  logic        entry_good;
  logic        last_digit;
  logic [2:0]  fail_next;
  logic        lock_start;
  logic        lock_busy;
  logic        lock_done;

  // Digit 0 sits in the top nibble and is keyed first.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign id_nib[gi]  = USER_ID[15 - 4*gi -: 4];
    assign pwd_nib[gi] = PASSWORD[15 - 4*gi -: 4];
  end

  assign digit_ok   = (state_reg == ST_ID_ENTRY) ? (bus.PassDigit == id_nib[idx_reg])
                                                 : (bus.PassDigit == pwd_nib[idx_reg]);
  assign entry_good = sofar_reg && digit_ok;
  assign last_digit = (state_reg == ST_PWD_ENTRY) && bus.LoadPassNumber && (idx_reg == LAST_IDX);
  assign fail_next  = fail_cnt_reg + 3'd1;
  assign lock_start = last_digit && !entry_good && (fail_next == 3'(MAX_FAIL));

  lockout_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_lockout_timer (
    .clk   (clk),
    .rst   (rst),
    .start (lock_start),
    .busy  (lock_busy),
    .done  (lock_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_ID_ENTRY;
      idx_reg      <= 2'd0;
      sofar_reg    <= 1'b1;
      fail_cnt_reg <= 3'd0;
      success_reg  <= 1'b0;
      rled_reg     <= 1'b1;
      gled_reg     <= 1'b0;
      locked_reg   <= 1'b0;
      disp_reg     <= DISP_IDLE;
    end else begin
      case (state_reg)
        ST_ID_ENTRY: if (bus.LoadPassNumber) begin
          sofar_reg <= entry_good;
          disp_reg  <= bus.PassDigit;
          if (idx_reg == LAST_IDX) begin
            state_reg <= ST_PWD_ENTRY;
            idx_reg   <= 2'd0;
          end else begin
            idx_reg <= idx_reg + 2'd1;
          end
        end
        ST_PWD_ENTRY: if (bus.LoadPassNumber) begin
          if (idx_reg == LAST_IDX) begin
            idx_reg   <= 2'd0;
            sofar_reg <= 1'b1;
            if (entry_good) begin
              state_reg    <= ST_AUTH_OK;
              fail_cnt_reg <= 3'd0;
              success_reg  <= 1'b1;
              gled_reg     <= 1'b1;
              rled_reg     <= 1'b0;
              disp_reg     <= DISP_MASK;
            end else begin
              fail_cnt_reg <= fail_next;
              disp_reg     <= DISP_ERR;
              locked_reg   <= lock_start;
              state_reg    <= lock_start ? ST_LOCKOUT : ST_ID_ENTRY;
            end
          end else begin
            idx_reg   <= idx_reg + 2'd1;
            sofar_reg <= entry_good;
            disp_reg  <= DISP_MASK;
          end
        end
        ST_AUTH_OK: if (bus.LogOut) begin
          state_reg   <= ST_ID_ENTRY;
          idx_reg     <= 2'd0;
          success_reg <= 1'b0;
          gled_reg    <= 1'b0;
          rled_reg    <= 1'b1;
          disp_reg    <= DISP_IDLE;
        end
        // An idle timer here means the interval was lost; leave rather than hang.
        ST_LOCKOUT: if (lock_done || !lock_busy) begin
          state_reg    <= ST_ID_ENTRY;
          idx_reg      <= 2'd0;
          locked_reg   <= 1'b0;
          fail_cnt_reg <= 3'd0;
          disp_reg     <= DISP_IDLE;
        end
        default: begin
          state_reg    <= ST_ID_ENTRY;
          idx_reg      <= 2'd0;
          sofar_reg    <= 1'b1;
          fail_cnt_reg <= 3'd0;
          success_reg  <= 1'b0;
          rled_reg     <= 1'b1;
          gled_reg     <= 1'b0;
          locked_reg   <= 1'b0;
          disp_reg     <= DISP_IDLE;
        end
      endcase
    end
  end

  assign bus.SuccessAuth = success_reg;
  assign bus.RLed        = rled_reg;
  assign bus.GLed        = gled_reg;
  assign bus.Locked      = locked_reg;
  assign bus.PwdDisp     = disp_reg;

endmodule

// File: tb/tb_auth_controller.sv
// Directed bench for auth_controller with a 20-cycle lockout; expected values
// are hand-derived from the entry/lockout rules.
module tb_auth_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  auth_controller_if bus ();

  auth_controller #(
    .USER_ID     (16'h1234),
    .PASSWORD    (16'h5678),
    .MAX_FAIL    (3),
    .LOCK_CYCLES (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packs {SuccessAuth, GLed, RLed} so one comparison covers all three.
  task automatic chk_auth(input string tag, input logic exp);
    chk(tag, 16'({bus.SuccessAuth, bus.GLed, bus.RLed}), 16'({exp, exp, ~exp}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input logic [3:0] d);
    bus.PassDigit      = d;
    bus.LoadPassNumber = 1'b1;
    tick();
    bus.LoadPassNumber = 1'b0;
  endtask

  task automatic enter(input logic [31:0] code);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) gap(3);
      press(code[31 - 4*i -: 4]);
    end
  endtask

  task automatic logout();
    bus.LogOut = 1'b1;
    tick();
    bus.LogOut = 1'b0;
  endtask

  initial begin
    logic [31:0] good;
    logic [31:0] bad;
    int          n;
    good = 32'h12345678;
    bad  = 32'h12945678;
    bus.PassDigit      = 4'd0;
    bus.LoadPassNumber = 1'b0;
    bus.LogOut         = 1'b0;

    // Reset state
    #12;
    chk("reset_leds", 16'({bus.SuccessAuth, bus.GLed, bus.RLed, bus.Locked}), 16'b0010);
    chk("reset_disp", 16'(bus.PwdDisp), 16'hF);
    @(negedge clk);
    rst = 1'b1;

    // 1: correct entry, ID echoed then masked, success one cycle after 8th press
    for (int i = 0; i < 8; i++) begin
      if (i > 0) gap(3);
      press(good[31 - 4*i -: 4]);
      chk("t1_disp", 16'(bus.PwdDisp), (i < 4) ? 16'(i + 1) : 16'hA);
      if (i == 6) chk_auth("t1_auth_before", 1'b0);
    end
    chk_auth("t1_auth", 1'b1);

    // 2: one wrong ID digit, no early indication, error on evaluation
    gap(3);
    logout();
    chk_auth("t2_logout", 1'b0);
    chk("t2_logout_disp", 16'(bus.PwdDisp), 16'hF);
    for (int i = 0; i < 7; i++) begin
      gap(3);
      press(bad[31 - 4*i -: 4]);
    end
    chk_auth("t2_auth_before", 1'b0);
    chk("t2_disp_before", 16'(bus.PwdDisp), 16'hA);
    gap(3);
    press(4'h8);
    chk_auth("t2_auth", 1'b0);
    chk("t2_disp_err", 16'(bus.PwdDisp), 16'hE);
    chk("t2_locked", 16'(bus.Locked), 16'h0);

    // 3: second and third failures -> lockout of exactly 20 cycles, presses ignored
    gap(3);
    enter(32'h11111111);
    chk("t3_locked_2nd", 16'(bus.Locked), 16'h0);
    chk("t3_disp_2nd", 16'(bus.PwdDisp), 16'hE);
    gap(3);
    enter(32'h11111111);
    chk("t3_locked_3rd", 16'(bus.Locked), 16'h1);
    n = 1;
    bus.PassDigit      = 4'h1;
    bus.LoadPassNumber = 1'b1;
    while (bus.Locked === 1'b1 && n <= 40) begin
      tick();
      if (bus.Locked === 1'b1) n++;
    end
    bus.LoadPassNumber = 1'b0;
    chk("t3_lock_len", 16'(n), 16'd20);
    chk("t3_unlocked", 16'(bus.Locked), 16'h0);
    chk("t3_disp_idle", 16'(bus.PwdDisp), 16'hF);
    gap(3);
    enter(good);
    chk_auth("t3_auth_after", 1'b1);

    // 4: LogOut and a press together; the press must not count as a digit
    gap(3);
    bus.LogOut         = 1'b1;
    bus.PassDigit      = 4'h1;
    bus.LoadPassNumber = 1'b1;
    tick();
    bus.LogOut         = 1'b0;
    bus.LoadPassNumber = 1'b0;
    chk_auth("t4_logout", 1'b0);
    chk("t4_disp", 16'(bus.PwdDisp), 16'hF);
    for (int d = 2; d <= 8; d++) begin
      gap(3);
      press(4'(d));
    end
    chk_auth("t4_not_auth", 1'b0);
    chk("t4_disp_mask", 16'(bus.PwdDisp), 16'hA);
    gap(3);
    press(4'h1);
    chk("t4_disp_err", 16'(bus.PwdDisp), 16'hE);

    // 5: async reset after five digits, then a clean entry
    for (int i = 0; i < 5; i++) begin
      gap(3);
      press(good[31 - 4*i -: 4]);
    end
    chk("t5_disp_mid", 16'(bus.PwdDisp), 16'hA);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("t5_reset_leds", 16'({bus.SuccessAuth, bus.GLed, bus.RLed, bus.Locked}), 16'b0010);
    chk("t5_reset_disp", 16'(bus.PwdDisp), 16'hF);
    #3;
    rst = 1'b1;
    gap(3);
    enter(good);
    chk_auth("t5_auth", 1'b1);

    // 6: success in between clears the failure count
    gap(3);
    logout();
    gap(3);
    enter(bad);
    gap(3);
    enter(bad);
    chk("t6_locked_a", 16'(bus.Locked), 16'h0);
    gap(3);
    enter(good);
    chk_auth("t6_auth", 1'b1);
    gap(3);
    logout();
    gap(3);
    enter(bad);
    gap(3);
    enter(bad);
    chk("t6_locked_b", 16'(bus.Locked), 16'h0);
    chk("t6_disp_err", 16'(bus.PwdDisp), 16'hE);
    gap(3);
    chk("t6_locked_c", 16'(bus.Locked), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
